io_input_sequencer: RTL

Sequencer for the input-instruction path of the single-cycle MIPS core. On a decoded IN instruction it holds the ProgramCounter through `halt` and waits for a debounced operator confirm press. It then captures the 16 switches, extends them to 32 bits and issues a one-cycle RegisterBank write to the destination register, releasing the PC on that same edge. It sits between the decoder, In_Module/switches, ProgramCounter and RegisterBank.

---
 rtl/io_input_sequencer.sv | 102 ++++++++++
 1 files changed

// File: rtl/io_input_sequencer.sv
// Stalls the PC on an IN instruction until a debounced release-then-press of confirm,
// then writes the extended switch word to the destination register for one cycle.
module io_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit SIGN_EXT        = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_instr,
    input  logic [4:0]  dest_reg,
    input  logic [15:0] switches,
    input  logic        confirm,
    input  logic        abort,
    output logic        halt,
    output logic        reg_write,
    output logic [4:0]  write_register,
    output logic [31:0] write_data,
    output logic        busy
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_RELEASE = 2'd1,
        WAIT_PRESS   = 2'd2,
        WRITE        = 2'd3
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [CW-1:0]  cnt;
    logic [4:0]     wr_addr;
    logic [31:0]    wr_data;
    logic [31:0]    ext_switches;
    logic           cancel;
    logic           awaited;
    logic           settled;

    assign ext_switches = SIGN_EXT ? {{16{switches[15]}}, switches} : {16'h0000, switches};

    // A PC redirect (in_instr dropping) cancels exactly like an explicit abort.
    assign cancel  = abort | ~in_instr;
    assign awaited = ((state == WAIT_RELEASE) & ~confirm) | ((state == WAIT_PRESS) & confirm);
    assign settled = awaited & (cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:         if (in_instr && !abort) next_state = WAIT_RELEASE;
            WAIT_RELEASE: if (cancel) next_state = IDLE;
                          else if (settled) next_state = WAIT_PRESS;
            WAIT_PRESS:   if (cancel) next_state = IDLE;
                          else if (settled) next_state = WRITE;
            WRITE:        next_state = IDLE;
            default:      next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (next_state != state) begin
                cnt <= '0;
            end else if (awaited) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (state == IDLE && next_state == WAIT_RELEASE) begin
                wr_addr <= dest_reg;
            end
            if (state == WAIT_PRESS && next_state == WRITE) begin
                wr_data <= ext_switches;
            end
        end
    end

    always_comb begin
        halt      = ((state == IDLE) & in_instr & ~abort)
                  | (state == WAIT_RELEASE) | (state == WAIT_PRESS);
        // A reset landing on the write cycle must not let the pulse through.
        reg_write = (state == WRITE) & ~reset;
        busy      = (state != IDLE);
    end

    assign write_register = wr_addr;
    assign write_data     = wr_data;

endmodule
